// File: rtl/psum_accumulator_if.sv
// Bundle between the cross-macro partial-sum stage, the accumulator and the
// next layer's input buffer. Upstream drives the pass inputs; the accumulator drives results.
interface psum_accumulator_if #(
    parameter int CHANNEL_NUM = 128,
    parameter int IN_WIDTH    = 6,
    parameter int ACC_WIDTH   = 10,
    parameter int PASS_NUM    = 9
);
    localparam int CNT_W = $clog2(PASS_NUM);

    logic                                  frame_start;
    logic                                  data_in_valid;
    logic [CHANNEL_NUM-1:0][IN_WIDTH-1:0]  data_in;
    logic [CHANNEL_NUM-1:0][ACC_WIDTH-1:0] threshold;

    logic                                  data_out_valid;
    logic [CHANNEL_NUM-1:0][ACC_WIDTH-1:0] sum_out;
    logic [CHANNEL_NUM-1:0]                act_out;
    logic [CNT_W-1:0]                      pass_cnt;
    logic                                  busy;

    modport master (
        output frame_start,
        output data_in_valid,
        output data_in,
        output threshold,
        input  data_out_valid,
        input  sum_out,
        input  act_out,
        input  pass_cnt,
        input  busy
    );

    modport slave (
        input  frame_start,
        input  data_in_valid,
        input  data_in,
        input  threshold,
        output data_out_valid,
        output sum_out,
        output act_out,
        output pass_cnt,
        output busy
    );
endinterface

// File: rtl/psum_accumulator.sv
// Accumulates PASS_NUM signed partial-sum passes per channel with sticky saturation,
// then emits the total and a threshold activation one cycle after the final pass.
module psum_accumulator #(
    parameter int CHANNEL_NUM = 128,
    parameter int IN_WIDTH    = 6,
    parameter int ACC_WIDTH   = 10,
    parameter int PASS_NUM    = 9
) (
    input  logic             clk,
    input  logic             rstn,
    psum_accumulator_if.slave bus
);
    localparam int CNT_W = $clog2(PASS_NUM);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] ACCUM = 1'b1;

    localparam logic [CNT_W-1:0] LAST_PASS = CNT_W'(PASS_NUM - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef logic [ACC_WIDTH-1:0] acc_t;

    function automatic acc_t sext(input logic [IN_WIDTH-1:0] v);
        return ACC_WIDTH'($signed(v));
    endfunction

    // One extra guard bit: overflow when the two top bits of the sum disagree,
    // in which case the guard bit gives the direction to clamp toward.
    function automatic void sat_add(input acc_t a, input logic [IN_WIDTH-1:0] d,
                                    output acc_t r, output logic ovf);
        acc_t               e;
        logic [ACC_WIDTH:0] s;
        e   = sext(d);
        s   = {a[ACC_WIDTH-1], a} + {e[ACC_WIDTH-1], e};
        ovf = s[ACC_WIDTH] ^ s[ACC_WIDTH-1];
        r   = ovf ? {s[ACC_WIDTH], {(ACC_WIDTH-1){~s[ACC_WIDTH]}}} : s[ACC_WIDTH-1:0];
    endfunction

    logic [0:0]                            state_q, state_d;
    logic [CNT_W-1:0]                      pass_cnt_q, pass_cnt_d;
    logic [CHANNEL_NUM-1:0][ACC_WIDTH-1:0] acc_q, acc_d;
    logic [CHANNEL_NUM-1:0]                sat_q, sat_d;
    logic [CHANNEL_NUM-1:0][ACC_WIDTH-1:0] sum_q, sum_d;
    logic [CHANNEL_NUM-1:0]                act_q, act_d;
    logic                                  out_valid_q, out_valid_d;

    logic [CHANNEL_NUM-1:0][ACC_WIDTH-1:0] nxt_acc;
    logic [CHANNEL_NUM-1:0]                nxt_sat;

    logic do_load;
    logic do_acc;
    logic do_fin;
    logic do_clr;

    // Running sum for each channel; a saturated channel holds its clamped value.
    always_comb begin
        acc_t r;
        logic ovf;
        nxt_acc = '0;
        nxt_sat = '0;
        for (int i = 0; i < CHANNEL_NUM; i++) begin
            r   = '0;
            ovf = 1'b0;
            sat_add(acc_q[i], bus.data_in[i], r, ovf);
            nxt_acc[i] = sat_q[i] ? acc_q[i] : r;
            nxt_sat[i] = sat_q[i] | ovf;
        end
    end

    // frame_start outranks completion: a coincident valid always restarts at pass 0.
    always_comb begin
        state_d     = state_q;
        pass_cnt_d  = pass_cnt_q;
        out_valid_d = 1'b0;
        do_load     = 1'b0;
        do_acc      = 1'b0;
        do_fin      = 1'b0;
        do_clr      = 1'b0;
        if (bus.frame_start) begin
            if (bus.data_in_valid) begin
                do_load    = 1'b1;
                state_d    = ACCUM;
                pass_cnt_d = CNT_ONE;
            end else begin
                do_clr     = 1'b1;
                state_d    = IDLE;
                pass_cnt_d = '0;
            end
        end else if (bus.data_in_valid) begin
            case (state_q)
                IDLE: begin
                    do_load    = 1'b1;
                    state_d    = ACCUM;
                    pass_cnt_d = CNT_ONE;
                end
                ACCUM: begin
                    if (pass_cnt_q == LAST_PASS) begin
                        do_fin      = 1'b1;
                        out_valid_d = 1'b1;
                        state_d     = IDLE;
                        pass_cnt_d  = '0;
                    end else begin
                        do_acc     = 1'b1;
                        pass_cnt_d = pass_cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    do_clr     = 1'b1;
                    state_d    = IDLE;
                    pass_cnt_d = '0;
                end
            endcase
        end
    end

    always_comb begin
        acc_d = acc_q;
        sat_d = sat_q;
        sum_d = sum_q;
        act_d = act_q;
        for (int i = 0; i < CHANNEL_NUM; i++) begin
            if (do_load) begin
                acc_d[i] = sext(bus.data_in[i]);
                sat_d[i] = 1'b0;
            end else if (do_acc) begin
                acc_d[i] = nxt_acc[i];
                sat_d[i] = nxt_sat[i];
            end else if (do_fin) begin
                sum_d[i] = nxt_acc[i];
                act_d[i] = $signed(nxt_acc[i]) >= $signed(bus.threshold[i]);
                acc_d[i] = '0;
                sat_d[i] = 1'b0;
            end else if (do_clr) begin
                acc_d[i] = '0;
                sat_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            pass_cnt_q  <= '0;
            acc_q       <= '0;
            sat_q       <= '0;
            sum_q       <= '0;
            act_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pass_cnt_q  <= pass_cnt_d;
            acc_q       <= acc_d;
            sat_q       <= sat_d;
            sum_q       <= sum_d;
            act_q       <= act_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.data_out_valid = out_valid_q;
    assign bus.sum_out        = sum_q;
    assign bus.act_out        = act_q;
    assign bus.pass_cnt       = pass_cnt_q;
    assign bus.busy           = (state_q == ACCUM);

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed and random passes into psum_accumulator; results are predicted by a
// behavioural model into a queue and compared whenever data_out_valid pulses.
module tb_psum_accumulator;
  localparam int CH = 128;
  localparam int IW = 6;
  localparam int AW = 10;
  localparam int PN = 9;
  localparam int MAXV = 511;
  localparam int MINV = -512;

  typedef logic [CH-1:0][AW-1:0] sum_vec_t;

  logic clk;
  logic rstn;

  psum_accumulator_if #(.CHANNEL_NUM(CH), .IN_WIDTH(IW), .ACC_WIDTH(AW), .PASS_NUM(PN)) b ();
  psum_accumulator_if #(.CHANNEL_NUM(4), .IN_WIDTH(IW), .ACC_WIDTH(8), .PASS_NUM(PN)) b8 ();

  psum_accumulator #(.CHANNEL_NUM(CH), .IN_WIDTH(IW), .ACC_WIDTH(AW), .PASS_NUM(PN)) u_dut (
    .clk(clk), .rstn(rstn), .bus(b)
  );
  psum_accumulator #(.CHANNEL_NUM(4), .IN_WIDTH(IW), .ACC_WIDTH(8), .PASS_NUM(PN)) u_dut8 (
    .clk(clk), .rstn(rstn), .bus(b8)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  sum_vec_t        exp_sum_q[$];
  logic [CH-1:0]   exp_act_q[$];
  logic [CH-1:0][IW-1:0] din;
  logic [CH-1:0][AW-1:0] thr;
  int acc_m[CH];
  bit sat_m[CH];
  int cnt_m;
  int total;
  int bad;
  int n_out;

  function automatic int sx(input logic [IW-1:0] v);
    return int'($signed(v));
  endfunction

  task automatic check(input string tag, input logic signed [63:0] o, input logic signed [63:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  task automatic tick();
    sum_vec_t es;
    logic [CH-1:0] ea;
    int k;
    @(posedge clk);
    #1;
    if (b.data_out_valid === 1'b1) begin
      n_out++;
      total++;
      assert (exp_sum_q.size() != 0) else begin
        bad++;
        $error("FAIL out_unexpected observed=pulse expected=no_pulse");
      end
      if (exp_sum_q.size() != 0) begin
        es = exp_sum_q.pop_front();
        ea = exp_act_q.pop_front();
        k = 0;
        for (int i = 0; i < CH; i++) begin
          if (b.sum_out[i] !== es[i]) begin
            k = i;
            break;
          end
        end
        total++;
        assert (b.sum_out === es) else begin
          bad++;
          $error("FAIL sum_vec ch%0d observed=%0d expected=%0d", k, $signed(b.sum_out[k]), $signed(es[k]));
        end
        total++;
        assert (b.act_out === ea) else begin
          bad++;
          $error("FAIL act_vec observed=%h expected=%h", b.act_out, ea);
        end
      end
    end
  endtask

  task automatic model_update(input bit fs);
    int t;
    sum_vec_t es;
    logic [CH-1:0] ea;
    if (fs || cnt_m == 0) begin
      for (int i = 0; i < CH; i++) begin
        acc_m[i] = sx(din[i]);
        sat_m[i] = 1'b0;
      end
      cnt_m = 1;
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (!sat_m[i]) begin
          t = acc_m[i] + sx(din[i]);
          if (t > MAXV) begin
            t = MAXV;
            sat_m[i] = 1'b1;
          end else if (t < MINV) begin
            t = MINV;
            sat_m[i] = 1'b1;
          end
          acc_m[i] = t;
        end
      end
      if (cnt_m == PN - 1) begin
        for (int i = 0; i < CH; i++) begin
          es[i] = AW'(acc_m[i]);
          ea[i] = (acc_m[i] >= int'($signed(thr[i])));
        end
        exp_sum_q.push_back(es);
        exp_act_q.push_back(ea);
        cnt_m = 0;
      end else begin
        cnt_m++;
      end
    end
  endtask

  // driver tasks
  task automatic pass(input bit fs);
    b.frame_start   = fs;
    b.data_in_valid = 1'b1;
    b.data_in       = din;
    b.threshold     = thr;
    model_update(fs);
    tick();
    b.frame_start   = 1'b0;
    b.data_in_valid = 1'b0;
  endtask

  task automatic fs_only();
    b.frame_start = 1'b1;
    cnt_m = 0;
    tick();
    b.frame_start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic set_all(input int v);
    for (int i = 0; i < CH; i++) din[i] = IW'(v);
  endtask

  task automatic set_thr(input int v);
    for (int i = 0; i < CH; i++) thr[i] = AW'(v);
  endtask

  task automatic pass8(input int v);
    for (int i = 0; i < 4; i++) b8.data_in[i] = IW'(v);
    b8.data_in_valid = 1'b1;
    tick();
    b8.data_in_valid = 1'b0;
  endtask

  initial begin
    int n0;
    int v;
    total = 0;
    bad = 0;
    n_out = 0;
    cnt_m = 0;
    rstn = 1'b0;
    din = '0;
    thr = '0;
    b.frame_start = 1'b0;
    b.data_in_valid = 1'b0;
    b.data_in = '0;
    b.threshold = '0;
    b8.frame_start = 1'b0;
    b8.data_in_valid = 1'b0;
    b8.data_in = '0;
    b8.threshold = '0;

    // reset state
    idle(2);
    check("rst_valid", b.data_out_valid, 0);
    check("rst_sum0", $signed(b.sum_out[0]), 0);
    check("rst_act_lo", b.act_out[63:0], 0);
    check("rst_act_hi", b.act_out[127:64], 0);
    check("rst_pass_cnt", b.pass_cnt, 0);
    check("rst_busy", b.busy, 0);
    rstn = 1'b1;
    idle(1);

    // 9 passes of +1, threshold 5
    set_all(1);
    set_thr(5);
    pass(0);
    check("t1_pass_cnt1", b.pass_cnt, 1);
    check("t1_busy1", b.busy, 1);
    repeat (PN - 2) pass(0);
    check("t1_pass_cnt8", b.pass_cnt, 8);
    check("t1_no_early_valid", b.data_out_valid, 0);
    pass(0);
    check("t1_valid", b.data_out_valid, 1);
    check("t1_sum0", $signed(b.sum_out[0]), 9);
    check("t1_sum127", $signed(b.sum_out[127]), 9);
    check("t1_act_lo", b.act_out[63:0], -1);
    check("t1_pass_cnt0", b.pass_cnt, 0);
    check("t1_busy0", b.busy, 0);
    idle(1);
    check("t1_valid_drop", b.data_out_valid, 0);
    check("t1_sum_hold", $signed(b.sum_out[0]), 9);

    // extremes on ch0 / ch1
    set_all(0);
    din[0] = IW'(-32);
    din[1] = IW'(31);
    set_thr(0);
    repeat (PN) pass(0);
    check("t2_sum0", $signed(b.sum_out[0]), -288);
    check("t2_act0", b.act_out[0], 0);
    check("t2_sum1", $signed(b.sum_out[1]), 279);
    check("t2_act1", b.act_out[1], 1);

    // threshold boundary
    for (int r = 0; r < 2; r++) begin
      set_thr(4 + r);
      set_all(1);
      repeat (4) pass(0);
      set_all(0);
      repeat (5) pass(0);
      check("t3_sum4", $signed(b.sum_out[0]), 4);
      check("t3_act_boundary", b.act_out[0], (r == 0) ? 1 : 0);
    end
    set_thr(-3);
    set_all(-1);
    repeat (3) pass(0);
    set_all(0);
    repeat (6) pass(0);
    check("t3_sum_neg", $signed(b.sum_out[0]), -3);
    check("t3_act_neg", b.act_out[0], 1);

    // frame_start discarding partial sums
    set_thr(5);
    set_all(7);
    repeat (4) pass(0);
    fs_only();
    check("t4_fs_pass_cnt", b.pass_cnt, 0);
    check("t4_fs_busy", b.busy, 0);
    n0 = n_out;
    set_all(1);
    repeat (PN) pass(0);
    check("t4_one_pulse", n_out - n0, 1);
    check("t4_sum", $signed(b.sum_out[0]), 9);
    n0 = n_out;
    repeat (PN - 1) pass(0);
    pass(1);
    check("t4_fs_final_no_valid", b.data_out_valid, 0);
    check("t4_fs_final_pass_cnt", b.pass_cnt, 1);
    check("t4_fs_final_pulses", n_out - n0, 0);
    repeat (PN - 1) pass(0);
    check("t4_resume_sum", $signed(b.sum_out[0]), 9);

    // alternating +2/-1 with gaps of 0 and 3
    set_thr(4);
    n0 = n_out;
    for (int k = 0; k < 2 * PN; k++) begin
      set_all((k % 2 == 0) ? 2 : -1);
      pass(0);
      if (k == PN - 1) check("t5_first_sum", $signed(b.sum_out[0]), 6);
      idle((k % 2 == 0) ? 0 : 3);
      if (k == PN) check("t5_hold_sum", $signed(b.sum_out[0]), 6);
    end
    check("t5_two_pulses", n_out - n0, 2);
    check("t5_second_sum", $signed(b.sum_out[0]), 3);
    check("t5_second_act", b.act_out[0], 0);

    // reset mid-accumulation
    set_all(1);
    repeat (5) pass(0);
    n0 = n_out;
    rstn = 1'b0;
    cnt_m = 0;
    idle(1);
    rstn = 1'b1;
    check("t6_no_pulse", n_out - n0, 0);
    check("t6_pass_cnt", b.pass_cnt, 0);
    check("t6_sum_cleared", $signed(b.sum_out[0]), 0);
    repeat (PN) pass(0);
    check("t6_sum", $signed(b.sum_out[0]), 9);

    // random passes with random gaps
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < CH; i++) thr[i] = AW'(int'($urandom_range(0, 600)) - 300);
      for (int p = 0; p < PN; p++) begin
        for (int i = 0; i < CH; i++) din[i] = IW'($urandom_range(0, 63));
        pass(0);
        idle($urandom_range(0, 2));
      end
    end
    idle(2);
    check("sb_drained", exp_sum_q.size(), 0);

    // narrow accumulator: saturation and stickiness
    for (int i = 0; i < 4; i++) b8.threshold[i] = 8'd0;
    repeat (PN) pass8(31);
    check("w8_valid", b8.data_out_valid, 1);
    check("w8_sat_sum", $signed(b8.sum_out[0]), 127);
    check("w8_sat_act", b8.act_out[0], 1);
    repeat (5) pass8(31);
    repeat (4) pass8(-32);
    check("w8_sticky_sum", $signed(b8.sum_out[3]), 127);
    v = 0;
    repeat (PN) pass8(-32);
    check("w8_neg_sat_sum", $signed(b8.sum_out[1]), -128);
    check("w8_neg_sat_act", b8.act_out[1], v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
